dmem_copy_engine: RTL and testbench
===================================

Name: dmem_copy_engine

Overview:
- Bus initiator for the single-port data memory (dmem).
- Drives the memory's write-enable, address and write-data lines, and consumes its combinational read data.
- Performs block copy (memmove semantics) or block fill of word-aligned regions on command from the control path.
- Sits beside the processor, which arbitrates the dmem port to this engine while busy=1.

Parameters:
- DEPTH, 64, words in the target dmem; legal byte addresses are 0 .. DEPTH*4-1.
- LEN_W, 7, width of len; must hold the values 0..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  command strobe; accepted only in IDLE
- mode  input  1  0 = copy, 1 = fill
- src_addr  input  32  copy source byte address; word aligned
- dst_addr  input  32  destination byte address; word aligned
- len  input  LEN_W  number of words
- fill_val  input  32  word written in fill mode
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  command rejected; valid with done, held until next accepted start
- mem_we  output  1  to dmem we
- mem_a  output  32  to dmem a (byte address)
- mem_wd  output  32  to dmem wd
- mem_rd  input  32  from dmem rd (combinational read of mem_a)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, err, mem_we, mem_a and mem_wd all go to 0.
  - Applies mid-operation too: the operation is aborted, words already written stay written, no done pulse.
- States: IDLE, RD, WR, FILL, DONE.
- IDLE:
  - Outputs idle at 0.
  - On start=1, latch mode/src/dst/len/fill_val and run the checks below.
  - err is set if any of these hold:
    - src_addr[1:0]!=0 or dst_addr[1:0]!=0
    - len>DEPTH
    - dst_addr+4*len > DEPTH*4
    - copy mode and src_addr+4*len > DEPTH*4
  - Address arithmetic is 33-bit, with no wrap.
  - err=1 -> DONE; no memory access occurs.
  - len=0 with no error -> DONE with err=0; no access.
  - Otherwise go to RD (copy) or FILL (fill), with index i initialised per direction.
- Direction:
  - Descending (i = len-1 down to 0) when copy and src < dst < src+4*len.
  - Ascending (i = 0 up to len-1) otherwise.
  - Fill is always ascending.
- RD:
  - mem_a = src+4i, mem_we=0.
  - Capture mem_rd into the data buffer at the clock edge, then go to WR.
- WR:
  - mem_a = dst+4i, mem_wd = buffer, mem_we=1.
  - If this is the last word go to DONE; otherwise advance i and go to RD.
- FILL:
  - mem_a = dst+4i, mem_wd = fill_val, mem_we=1.
  - Advance i each cycle; go to DONE after the last word.
- DONE: done=1 for exactly one cycle, busy=1, mem_we=0, then go to IDLE.
- start outside IDLE is ignored, including in the DONE cycle.
- Latency, counted from the start-accept edge to the done cycle:
  - copy: 2*len+1 cycles
  - fill: len+1 cycles
  - error or len=0: 1 cycle
- mem_we is never asserted in IDLE, RD or DONE.
- Exactly len writes per accepted, error-free command.
- mem_a and mem_wd are registered outputs; glitch-free with respect to the clock.

Test Plan:
- Copy, ascending:
  - Setup: dmem preloaded with word k = 0x100+k. Start copy src=0x00, dst=0x80, len=4.
  - Expect: words 32..35 = 0x100..0x103; done pulse 9 cycles after accept; err=0; exactly 4 mem_we pulses.
- Fill:
  - Stimulus: start fill dst=0x10, len=3, fill_val=0xDEADBEEF.
  - Expect: words 4..6 = 0xDEADBEEF; word 7 unchanged; done 4 cycles after accept.
- Overlapping copy, descending:
  - Stimulus: src=0x00, dst=0x08, len=4, with words 0..3 = A,B,C,D.
  - Expect: words 2..5 = A,B,C,D; write order hits addresses 0x14, 0x10, 0x0C, 0x08.
- Errors:
  - dst=0x06 -> done+err after 1 cycle, no mem_we.
  - dst=0xF8, len=3 -> err.
  - len=0 -> done with err=0 and no access.
- Reset and start handling:
  - Assert rst_n=0 during the 3rd word of a len=8 copy.
  - Expect: next cycle busy=0 and all outputs 0; only words 0..1 written; no done pulse.
  - A new start then completes normally.
  - start pulsed while busy is ignored: the first command completes untouched and exactly one done pulse occurs.

Source files
------------

// File: rtl/dmem_copy_engine_if.sv
// Command and dmem bus bundle for dmem_copy_engine.
// master: the copy engine (dmem initiator); slave: control path plus dmem.
interface dmem_copy_engine_if #(
  parameter int unsigned LEN_W = 7
);
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic [31:0]      fill_val;
  logic             busy;
  logic             done;
  logic             err;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, mem_rd,
    output busy, done, err, mem_we, mem_a, mem_wd
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rd,
    input  busy, done, err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// Block copy (memmove semantics) / block fill engine driving the single-port dmem.
// All bus-facing outputs are registered and derived from the next state.
module dmem_copy_engine #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LEN_W = 7
) (
  input logic                clk,
  input logic                rst_n,
  dmem_copy_engine_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_FILL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH * 4);

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      fill_q, fill_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             desc_q, desc_d;
  logic             err_q, err_d;
  logic             busy_q, done_q;
  logic             we_q, we_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      wd_q, wd_d;

  logic [32:0]      len_bytes, src_end, dst_end;
  logic             cmd_err, cmd_desc;
  logic [LEN_W-1:0] idx_init, idx_step;

  function automatic logic [31:0] word_off(input logic [LEN_W-1:0] i);
    return 32'(i) << 2;
  endfunction

  // Command checks use 33-bit sums so an end address past 4 GiB cannot wrap into range.
  assign len_bytes = 33'(bus.len) << 2;
  assign src_end   = {1'b0, bus.src_addr} + len_bytes;
  assign dst_end   = {1'b0, bus.dst_addr} + len_bytes;

  assign cmd_err = (|bus.src_addr[1:0]) | (|bus.dst_addr[1:0]) |
                   (33'(bus.len) > 33'(DEPTH)) | (dst_end > MEM_BYTES) |
                   (!bus.mode && (src_end > MEM_BYTES));

  // Copy backwards when the destination starts inside the source window.
  assign cmd_desc = !bus.mode && (bus.src_addr < bus.dst_addr) &&
                    ({1'b0, bus.dst_addr} < src_end);

  assign idx_init = cmd_desc ? bus.len - LEN_W'(1) : '0;
  assign idx_step = desc_q ? idx_q - LEN_W'(1) : idx_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    err_d   = err_q;
    we_d    = 1'b0;
    a_d     = '0;
    wd_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          fill_d = bus.fill_val;
          desc_d = cmd_desc;
          idx_d  = idx_init;
          cnt_d  = bus.len;
          err_d  = cmd_err;
          if (cmd_err || (bus.len == '0)) begin
            state_d = ST_DONE;
          end else if (bus.mode) begin
            state_d = ST_FILL;
            we_d    = 1'b1;
            a_d     = bus.dst_addr + word_off(idx_init);
            wd_d    = bus.fill_val;
          end else begin
            state_d = ST_RD;
            a_d     = bus.src_addr + word_off(idx_init);
          end
        end
      end
      ST_RD: begin
        // The write-data register doubles as the copy buffer.
        state_d = ST_WR;
        we_d    = 1'b1;
        a_d     = dst_q + word_off(idx_q);
        wd_d    = bus.mem_rd;
      end
      ST_WR: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
          idx_d   = idx_step;
          cnt_d   = cnt_q - LEN_W'(1);
          a_d     = src_q + word_off(idx_step);
        end
      end
      ST_FILL: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_step;
          cnt_d = cnt_q - LEN_W'(1);
          we_d  = 1'b1;
          a_d   = dst_q + word_off(idx_step);
          wd_d  = fill_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.mem_we = we_q;
  assign bus.mem_a  = a_q;
  assign bus.mem_wd = wd_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a behavioural 64-word dmem.
module tb_dmem_copy_engine;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LEN_W = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dmem_copy_engine_if #(.LEN_W(LEN_W)) bus ();

  dmem_copy_engine #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem      [DEPTH];
  logic [31:0] init_val [DEPTH];
  logic        load = 1'b0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_log [$];

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_val[k];
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
    if (bus.mem_we) begin
      we_cnt <= we_cnt + 1;
      wr_log.push_back(bus.mem_a);
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < DEPTH; k++) init_val[k] = 32'h100 + 32'(k);
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic set_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input logic [31:0] fv);
    bus.mode     = m;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.len      = l;
    bus.fill_val = fv;
  endtask

  // Latency n: done first seen n cycles after the accept edge; 0 means it never came.
  task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input logic [31:0] fv,
                         output int lat, output logic e);
    set_cmd(m, s, d, l, fv);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    e   = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (bus.done) begin
        lat = n;
        e   = bus.err;
        break;
      end
      tick();
    end
    tick();
  endtask

  int   lat;
  logic e;
  int   we0, log0, done0;

  initial begin
    bus.start = 1'b0;
    set_cmd(1'b0, '0, '0, '0, '0);
    repeat (2) tick();
    check_eq("rst_busy",   32'(bus.busy),   32'd0);
    check_eq("rst_done",   32'(bus.done),   32'd0);
    check_eq("rst_err",    32'(bus.err),    32'd0);
    check_eq("rst_we",     32'(bus.mem_we), 32'd0);
    check_eq("rst_a",      bus.mem_a,       32'd0);
    check_eq("rst_wd",     bus.mem_wd,      32'd0);
    rst_n = 1'b1;
    tick();

    // Ascending copy
    set_pattern();
    do_load();
    we0 = we_cnt;
    run_cmd(1'b0, 32'h00, 32'h80, 7'd4, 32'h0, lat, e);
    check_eq("cp_lat", 32'(lat), 32'd9);
    check_eq("cp_err", 32'(e), 32'd0);
    check_eq("cp_wes", 32'(we_cnt - we0), 32'd4);
    for (int k = 0; k < 4; k++) check_eq("cp_word", mem[32+k], 32'h100 + 32'(k));
    check_eq("cp_word36", mem[36], 32'h124);
    check_eq("cp_idle", 32'(bus.busy), 32'd0);

    // Fill
    we0 = we_cnt;
    run_cmd(1'b1, 32'h00, 32'h10, 7'd3, 32'hDEADBEEF, lat, e);
    check_eq("fill_lat", 32'(lat), 32'd4);
    check_eq("fill_err", 32'(e), 32'd0);
    check_eq("fill_wes", 32'(we_cnt - we0), 32'd3);
    for (int k = 4; k < 7; k++) check_eq("fill_word", mem[k], 32'hDEADBEEF);
    check_eq("fill_word7", mem[7], 32'h107);

    // Overlapping copy must run descending
    set_pattern();
    init_val[0] = 32'hAAAA0000;
    init_val[1] = 32'hBBBB0001;
    init_val[2] = 32'hCCCC0002;
    init_val[3] = 32'hDDDD0003;
    do_load();
    log0 = wr_log.size();
    run_cmd(1'b0, 32'h00, 32'h08, 7'd4, 32'h0, lat, e);
    check_eq("ov_lat", 32'(lat), 32'd9);
    check_eq("ov_nwr", 32'(wr_log.size() - log0), 32'd4);
    check_eq("ov_w0", mem[0], 32'hAAAA0000);
    check_eq("ov_w2", mem[2], 32'hAAAA0000);
    check_eq("ov_w3", mem[3], 32'hBBBB0001);
    check_eq("ov_w4", mem[4], 32'hCCCC0002);
    check_eq("ov_w5", mem[5], 32'hDDDD0003);
    check_eq("ov_a0", wr_log[log0],   32'h14);
    check_eq("ov_a1", wr_log[log0+1], 32'h10);
    check_eq("ov_a2", wr_log[log0+2], 32'h0C);
    check_eq("ov_a3", wr_log[log0+3], 32'h08);

    // Rejected and empty commands
    we0 = we_cnt;
    run_cmd(1'b0, 32'h00, 32'h06, 7'd1, 32'h0, lat, e);
    check_eq("misal_lat", 32'(lat), 32'd1);
    check_eq("misal_err", 32'(e), 32'd1);
    check_eq("misal_wes", 32'(we_cnt - we0), 32'd0);
    repeat (2) tick();
    check_eq("err_held", 32'(bus.err), 32'd1);
    check_eq("err_idle", 32'(bus.busy), 32'd0);
    run_cmd(1'b1, 32'h00, 32'hF8, 7'd3, 32'h1, lat, e);
    check_eq("oob_lat", 32'(lat), 32'd1);
    check_eq("oob_err", 32'(e), 32'd1);
    run_cmd(1'b0, 32'h00, 32'h00, 7'd65, 32'h0, lat, e);
    check_eq("len_err", 32'(e), 32'd1);
    run_cmd(1'b0, 32'hC0, 32'h00, 7'd17, 32'h0, lat, e);
    check_eq("src_oob_err", 32'(e), 32'd1);
    check_eq("err_wes", 32'(we_cnt - we0), 32'd0);
    we0 = we_cnt;
    run_cmd(1'b0, 32'h00, 32'h40, 7'd0, 32'h0, lat, e);
    check_eq("len0_lat", 32'(lat), 32'd1);
    check_eq("len0_err", 32'(e), 32'd0);
    check_eq("len0_wes", 32'(we_cnt - we0), 32'd0);
    run_cmd(1'b1, 32'h00, 32'hF4, 7'd3, 32'h77, lat, e);
    check_eq("edge_lat", 32'(lat), 32'd4);
    check_eq("edge_err", 32'(e), 32'd0);
    check_eq("edge_w63", mem[63], 32'h77);

    // Reset during the third word of an 8-word copy
    set_pattern();
    do_load();
    we0   = we_cnt;
    done0 = done_cnt;
    set_cmd(1'b0, 32'h00, 32'h80, 7'd8, 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check_eq("mid_rd_a", bus.mem_a, 32'h08);
    rst_n = 1'b0;
    tick();
    check_eq("mid_busy", 32'(bus.busy),   32'd0);
    check_eq("mid_done", 32'(bus.done),   32'd0);
    check_eq("mid_we",   32'(bus.mem_we), 32'd0);
    check_eq("mid_a",    bus.mem_a,       32'd0);
    check_eq("mid_wd",   bus.mem_wd,      32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("mid_wes",   32'(we_cnt - we0),     32'd2);
    check_eq("mid_dones", 32'(done_cnt - done0), 32'd0);
    check_eq("mid_w32",   mem[32], 32'h100);
    check_eq("mid_w33",   mem[33], 32'h101);
    check_eq("mid_w34",   mem[34], 32'h122);
    run_cmd(1'b1, 32'h00, 32'h00, 7'd2, 32'h55, lat, e);
    check_eq("post_lat", 32'(lat), 32'd3);
    check_eq("post_w1",  mem[1], 32'h55);

    // start while busy, including during the done cycle, must be ignored
    set_pattern();
    do_load();
    we0   = we_cnt;
    done0 = done_cnt;
    lat   = 0;
    set_cmd(1'b0, 32'h00, 32'h40, 7'd2, 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n == 2) begin
        set_cmd(1'b1, 32'h00, 32'hC0, 7'd2, 32'h99);
        bus.start = 1'b1;
      end
      if (n == 3) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        break;
      end
      tick();
    end
    repeat (3) tick();
    check_eq("ign_lat",   32'(lat), 32'd5);
    check_eq("ign_dones", 32'(done_cnt - done0), 32'd1);
    check_eq("ign_wes",   32'(we_cnt - we0), 32'd2);
    check_eq("ign_idle",  32'(bus.busy), 32'd0);
    check_eq("ign_w16",   mem[16], 32'h100);
    check_eq("ign_w17",   mem[17], 32'h101);
    check_eq("ign_w48",   mem[48], 32'h130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
